// File: rtl/vending_machine_param_pkg.sv
// ============================================================================
// Module  : vending_pkg
// Brief   : Shared constants for the vending machine: service codes, FSM
//           states, coin denominations, price table and reset stock.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

    localparam logic [1:0] c_SVC_OFF    = 2'b00;
    localparam logic [1:0] c_SVC_ON     = 2'b01;
    localparam logic [1:0] c_SVC_BUSY   = 2'b10;
    localparam logic [1:0] c_SVC_REFUND = 2'b11;

    typedef enum logic [2:0] {
        ST_ON          = 3'd0,
        ST_BUSY_CHECK  = 3'd1,
        ST_BUSY_CHANGE = 3'd2,
        ST_REFUND      = 3'd3,
        ST_OFF         = 3'd4
    } state_t;

    localparam int c_DENOM_1  = 1;
    localparam int c_DENOM_5  = 5;
    localparam int c_DENOM_10 = 10;

    // Indexed by item code; entry 0 is the "no item" slot.
    localparam int c_PRICE [8] = '{0, 8, 15, 23, 37, 50, 50, 50};

    localparam int c_RST_STOCK_1  = 5;
    localparam int c_RST_STOCK_5  = 2;
    localparam int c_RST_STOCK_10 = 2;

endpackage

`default_nettype wire

// File: rtl/vending_machine_param_if.sv
// ============================================================================
// Module  : vending_machine_param_if
// Brief   : Customer-facing coin/item bus; z0..z2 exist only when
//           VENDING_PROP_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vending_machine_param_if #(
    parameter int CNT_W = 4
);
    logic [1:0]       coin_in_1;
    logic [1:0]       coin_in_5;
    logic [1:0]       coin_in_10;
    logic [2:0]       item_in;
    logic [CNT_W-1:0] coin_out_1;
    logic [CNT_W-1:0] coin_out_5;
    logic [CNT_W-1:0] coin_out_10;
    logic [2:0]       item_out;
    logic [1:0]       service;
`ifdef VENDING_PROP_EN
    logic             z0;
    logic             z1;
    logic             z2;

    modport master (
        output coin_in_1, coin_in_5, coin_in_10, item_in,
        input  coin_out_1, coin_out_5, coin_out_10, item_out, service, z0, z1, z2
    );
    modport slave (
        input  coin_in_1, coin_in_5, coin_in_10, item_in,
        output coin_out_1, coin_out_5, coin_out_10, item_out, service, z0, z1, z2
    );
`else
    modport master (
        output coin_in_1, coin_in_5, coin_in_10, item_in,
        input  coin_out_1, coin_out_5, coin_out_10, item_out, service
    );
    modport slave (
        input  coin_in_1, coin_in_5, coin_in_10, item_in,
        output coin_out_1, coin_out_5, coin_out_10, item_out, service
    );
`endif
endinterface

`default_nettype wire

// File: rtl/vending_machine_param_change_sel.sv
// ============================================================================
// Module  : vending_change_sel
// Brief   : Greedy largest-first coin picker; one-hot select {10,5,1} plus a
//           stuck flag when change remains but no usable coin is in stock.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_change_sel
    import vending_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int VAL_W = 10
) (
    input  wire logic [VAL_W-1:0] i_change,
    input  wire logic [CNT_W-1:0] i_stock_1,
    input  wire logic [CNT_W-1:0] i_stock_5,
    input  wire logic [CNT_W-1:0] i_stock_10,
    output logic      [2:0]       o_sel,
    output logic                  o_stuck
);

    always_comb begin
        o_sel = 3'b000;
        if ((i_change >= VAL_W'(c_DENOM_10)) && (i_stock_10 != '0)) begin
            o_sel = 3'b100;
        end else if ((i_change >= VAL_W'(c_DENOM_5)) && (i_stock_5 != '0)) begin
            o_sel = 3'b010;
        end else if ((i_change >= VAL_W'(c_DENOM_1)) && (i_stock_1 != '0)) begin
            o_sel = 3'b001;
        end
    end

    assign o_stuck = (i_change != '0) && (o_sel == 3'b000);

endmodule

`default_nettype wire

// File: rtl/vending_machine_param.sv
// ============================================================================
// Module  : vending_machine_param
// Brief   : Coin-stock vending controller with greedy change payout and a
//           one-shot refund path. Define VENDING_PROP_EN for z0..z2 monitors.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine_param #(
    parameter int NUM_ITEMS = 4,
    parameter int CNT_W     = 4,
    parameter int VAL_W     = 10
) (
    input  wire logic              clk,
    input  wire logic              reset,
    vending_machine_param_if.slave bus
);
    import vending_pkg::*;

    localparam logic [2:0] c_MAX_ITEM = 3'(NUM_ITEMS);

    state_t           r_state;
    logic [1:0]       r_service;
    logic [2:0]       r_item_out;
    logic [CNT_W-1:0] r_stock [3];
    logic [CNT_W-1:0] r_out   [3];
    logic [VAL_W-1:0] r_input_value;
    logic [VAL_W-1:0] r_price;
    logic [VAL_W-1:0] r_change;
    logic             r_refunded;

    logic [1:0]       w_coin_in   [3];
    logic [CNT_W-1:0] w_stock_sat [3];
    logic [VAL_W-1:0] w_input_value;
    logic [VAL_W-1:0] w_sel_value;
    logic [2:0]       w_sel;
    logic             w_stuck;
    logic             w_item_valid;

    assign w_coin_in[0] = bus.coin_in_1;
    assign w_coin_in[1] = bus.coin_in_5;
    assign w_coin_in[2] = bus.coin_in_10;

    assign w_input_value = VAL_W'(bus.coin_in_1)
                         + VAL_W'(bus.coin_in_5)  * VAL_W'(c_DENOM_5)
                         + VAL_W'(bus.coin_in_10) * VAL_W'(c_DENOM_10);
    assign w_item_valid  = (bus.item_in != 3'd0) && (bus.item_in <= c_MAX_ITEM);

    // Coins beyond a full tube are kept by the machine but not stocked.
    for (genvar d = 0; d < 3; d++) begin : g_sat
        logic [CNT_W:0] w_sum;
        assign w_sum          = {1'b0, r_stock[d]} + (CNT_W+1)'(w_coin_in[d]);
        assign w_stock_sat[d] = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    vending_change_sel #(
        .CNT_W (CNT_W),
        .VAL_W (VAL_W)
    ) u_change_sel (
        .i_change   (r_change),
        .i_stock_1  (r_stock[0]),
        .i_stock_5  (r_stock[1]),
        .i_stock_10 (r_stock[2]),
        .o_sel      (w_sel),
        .o_stuck    (w_stuck)
    );

    always_comb begin
        w_sel_value = '0;
        if (w_sel[2])      w_sel_value = VAL_W'(c_DENOM_10);
        else if (w_sel[1]) w_sel_value = VAL_W'(c_DENOM_5);
        else if (w_sel[0]) w_sel_value = VAL_W'(c_DENOM_1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_ON;
            r_service     <= c_SVC_ON;
            r_item_out    <= 3'd0;
            r_stock[0]    <= CNT_W'(c_RST_STOCK_1);
            r_stock[1]    <= CNT_W'(c_RST_STOCK_5);
            r_stock[2]    <= CNT_W'(c_RST_STOCK_10);
            for (int d = 0; d < 3; d++) r_out[d] <= '0;
            r_input_value <= '0;
            r_price       <= '0;
            r_change      <= '0;
            r_refunded    <= 1'b0;
        end else begin
            case (r_state)
                ST_ON: begin
                    if (w_item_valid) begin
                        r_input_value <= w_input_value;
                        r_price       <= VAL_W'(c_PRICE[bus.item_in]);
                        r_item_out    <= bus.item_in;
                        for (int d = 0; d < 3; d++) begin
                            r_out[d]   <= '0;
                            r_stock[d] <= w_stock_sat[d];
                        end
                        r_refunded    <= 1'b0;
                        r_state       <= ST_BUSY_CHECK;
                        r_service     <= c_SVC_BUSY;
                    end
                end
                ST_BUSY_CHECK: begin
                    if (r_input_value < r_price) begin
                        r_item_out <= 3'd0;
                        r_change   <= r_input_value;
                    end else begin
                        r_change   <= r_input_value - r_price;
                    end
                    r_state <= ST_BUSY_CHANGE;
                end
                ST_BUSY_CHANGE: begin
                    if (r_change == '0) begin
                        r_state   <= ST_OFF;
                        r_service <= c_SVC_OFF;
                    end else if (w_stuck) begin
                        // Only one refund attempt; a second dead end closes out as-is.
                        r_state   <= r_refunded ? ST_OFF : ST_REFUND;
                        r_service <= r_refunded ? c_SVC_OFF : c_SVC_REFUND;
                    end else begin
                        for (int d = 0; d < 3; d++) begin
                            if (w_sel[d]) begin
                                r_out[d]   <= r_out[d] + CNT_W'(1);
                                r_stock[d] <= r_stock[d] - CNT_W'(1);
                            end
                        end
                        r_change <= r_change - w_sel_value;
                    end
                end
                ST_REFUND: begin
                    for (int d = 0; d < 3; d++) begin
                        r_stock[d] <= r_stock[d] + r_out[d];
                        r_out[d]   <= '0;
                    end
                    r_item_out <= 3'd0;
                    r_change   <= r_input_value;
                    r_refunded <= 1'b1;
                    r_state    <= ST_BUSY_CHANGE;
                    r_service  <= c_SVC_BUSY;
                end
                ST_OFF: begin
                    for (int d = 0; d < 3; d++) r_out[d] <= '0;
                    r_item_out <= 3'd0;
                    r_state    <= ST_ON;
                    r_service  <= c_SVC_ON;
                end
                default: begin
                    r_state   <= ST_ON;
                    r_service <= c_SVC_ON;
                end
            endcase
        end
    end

    assign bus.coin_out_1  = r_out[0];
    assign bus.coin_out_5  = r_out[1];
    assign bus.coin_out_10 = r_out[2];
    assign bus.item_out    = r_item_out;
    assign bus.service     = r_service;

`ifdef VENDING_PROP_EN
    logic [VAL_W-1:0] r_ledger;
    logic [VAL_W-1:0] w_paid;
    logic [VAL_W-1:0] w_total;
    logic [VAL_W-1:0] w_loss;
    logic [VAL_W-1:0] w_price_paid;

    assign w_paid = VAL_W'(r_out[0])
                  + VAL_W'(r_out[1]) * VAL_W'(c_DENOM_5)
                  + VAL_W'(r_out[2]) * VAL_W'(c_DENOM_10);
    assign w_total = w_paid + VAL_W'(r_stock[0])
                   + VAL_W'(r_stock[1]) * VAL_W'(c_DENOM_5)
                   + VAL_W'(r_stock[2]) * VAL_W'(c_DENOM_10);
    assign w_loss = (VAL_W'(w_coin_in[0]) - (VAL_W'(w_stock_sat[0]) - VAL_W'(r_stock[0])))
                  + (VAL_W'(w_coin_in[1]) - (VAL_W'(w_stock_sat[1]) - VAL_W'(r_stock[1]))) * VAL_W'(c_DENOM_5)
                  + (VAL_W'(w_coin_in[2]) - (VAL_W'(w_stock_sat[2]) - VAL_W'(r_stock[2]))) * VAL_W'(c_DENOM_10);
    assign w_price_paid = (r_item_out != 3'd0) ? r_price : '0;

    // Value the machine should hold: grows by stocked input, shrinks by the change owed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ledger <= VAL_W'(c_RST_STOCK_1 * c_DENOM_1 + c_RST_STOCK_5 * c_DENOM_5
                             + c_RST_STOCK_10 * c_DENOM_10);
        end else if ((r_state == ST_ON) && w_item_valid) begin
            r_ledger <= r_ledger + w_input_value - w_loss;
        end else if (r_state == ST_OFF) begin
            r_ledger <= r_ledger - (r_input_value - w_price_paid);
        end
    end

    assign bus.z0 = reset && (r_service == c_SVC_ON) && (r_item_out != 3'd0);
    assign bus.z1 = reset && (r_service == c_SVC_OFF) && (r_input_value != (w_paid + w_price_paid));
    assign bus.z2 = reset && (w_total != r_ledger);
`endif

endmodule

`default_nettype wire
